// File: rtl/btle_rx_pdu_writer.sv
// Packs the de-whitened BLE PDU bit stream LSB-first into bytes and writes them
// into the receive-packet RAM, using the header length field to find the end.
module btle_rx_pdu_writer #(
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     pkt_ack,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [7:0]               ram_wr_data,
  output logic                     ram_wr_en,
  output logic                     pkt_ready,
  output logic [8:0]               pkt_len,
  output logic                     pkt_overflow,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, READY} state_t;

  localparam logic [9:0] DEPTH = 10'd1 << ADDRESS_WIDTH;

  state_t                   state_reg, state_next;
  logic [7:1]               sr_reg, sr_next;
  logic [2:0]               bit_cnt_reg, bit_cnt_next;
  logic [8:0]               byte_cnt_reg, byte_cnt_next;
  logic [7:0]               len_reg, len_next;
  logic                     wr_en_reg, wr_en_next;
  logic [ADDRESS_WIDTH-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]               wr_data_reg, wr_data_next;
  logic                     ready_reg, ready_next;
  logic [8:0]               pkt_len_reg, pkt_len_next;
  logic                     ovf_reg, ovf_next;
  logic                     busy_reg, busy_next;
  logic [7:0]               drop_reg, drop_next;

  logic [7:0] new_byte;
  logic [8:0] total;
  logic       restart;

  assign new_byte = {bit_in, sr_reg};
  assign total    = {1'b0, len_reg} + 9'd5;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sr_reg       <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      len_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      ready_reg    <= 1'b0;
      pkt_len_reg  <= '0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      sr_reg       <= sr_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      len_reg      <= len_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      ready_reg    <= ready_next;
      pkt_len_reg  <= pkt_len_next;
      ovf_reg      <= ovf_next;
      busy_reg     <= busy_next;
      drop_reg     <= drop_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sr_next       = sr_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    len_next      = len_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    pkt_len_next  = pkt_len_reg;
    ovf_next      = ovf_reg;
    drop_next     = drop_reg;
    restart       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = HEADER;
          restart    = 1'b1;
        end
      end

      HEADER, PAYLOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = HEADER;
          restart    = 1'b1;
        end else if (state_reg == PAYLOAD && byte_cnt_reg == total) begin
          // One cycle after the final byte edge, so the last write has landed.
          state_next   = READY;
          pkt_len_next = byte_cnt_reg;
        end else if (bit_valid) begin
          sr_next      = new_byte[7:1];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            byte_cnt_next = byte_cnt_reg + 9'd1;
            if ({1'b0, byte_cnt_reg} < DEPTH) begin
              wr_en_next   = 1'b1;
              wr_addr_next = byte_cnt_reg[ADDRESS_WIDTH-1:0];
              wr_data_next = new_byte;
            end else begin
              ovf_next = 1'b1;
            end
            if (byte_cnt_reg == 9'd1) begin
              len_next   = new_byte;
              state_next = PAYLOAD;
            end
          end
        end
      end

      READY: begin
        if (pkt_ack) begin
          if (start) begin
            state_next = HEADER;
            restart    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (start && drop_reg != 8'hFF) begin
          drop_next = drop_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (restart) begin
      sr_next       = '0;
      bit_cnt_next  = '0;
      byte_cnt_next = '0;
      len_next      = '0;
      pkt_len_next  = '0;
      ovf_next      = 1'b0;
    end

    busy_next  = (state_next == HEADER) || (state_next == PAYLOAD);
    ready_next = (state_next == READY);
  end

  assign ram_wr_addr  = wr_addr_reg;
  assign ram_wr_data  = wr_data_reg;
  assign ram_wr_en    = wr_en_reg;
  assign pkt_ready    = ready_reg;
  assign pkt_len      = pkt_len_reg;
  assign pkt_overflow = ovf_reg;
  assign busy         = busy_reg;
  assign drop_cnt     = drop_reg;

endmodule

// File: tb/tb_btle_rx_pdu_writer.sv
// Drives a 64-byte and a 16-byte instance with one shared bit stream; RAM writes
// are checked against a scoreboard queue per instance, status against a table.
module tb_btle_rx_pdu_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, pkt_ack = 1'b0;

  logic [5:0] wa6;
  logic [3:0] wa4;
  logic [7:0] wd6, wd4, drop6, drop4;
  logic       we6, we4, rdy6, rdy4, ov6, ov4, busy6, busy4;
  logic [8:0] len6, len4;

  int vectors = 0;
  int miscompares = 0;
  int idx = 0;
  int exp_drop = 0;
  logic [15:0] q6[$];
  logic [15:0] q4[$];

  typedef struct {
    logic [7:0] hdr0;
    logic [7:0] len;
    int         gap;
    int         exp_len;
    int         exp_ov6;
    int         exp_ov4;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  btle_rx_pdu_writer #(.ADDRESS_WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .pkt_ack(pkt_ack), .ram_wr_addr(wa6), .ram_wr_data(wd6),
    .ram_wr_en(we6), .pkt_ready(rdy6), .pkt_len(len6), .pkt_overflow(ov6),
    .busy(busy6), .drop_cnt(drop6)
  );

  btle_rx_pdu_writer #(.ADDRESS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .pkt_ack(pkt_ack), .ram_wr_addr(wa4), .ram_wr_data(wd4),
    .ram_wr_en(we4), .pkt_ready(rdy4), .pkt_len(len4), .pkt_overflow(ov4),
    .busy(busy4), .drop_cnt(drop4)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every RAM write must match the oldest expected write for that instance.
  always @(negedge clk) begin
    logic [15:0] e;
    if (we6) begin
      if (q6.size() == 0) chk("wr6_unexpected", 1, 0);
      else begin
        e = q6.pop_front();
        chk("wr6_addr", int'(wa6), int'(e[15:8]));
        chk("wr6_data", int'(wd6), int'(e[7:0]));
        $display("wr6 addr=%0d data=%02h", wa6, wd6);
      end
    end
    if (we4) begin
      if (q4.size() == 0) chk("wr4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        chk("wr4_addr", int'(wa4), int'(e[15:8]));
        chk("wr4_data", int'(wd4), int'(e[7:0]));
        $display("wr4 addr=%0d data=%02h", wa4, wd4);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    if (idx < 64) q6.push_back({8'(idx), v});
    if (idx < 16) q4.push_back({8'(idx), v});
    idx++;
    for (int i = 0; i < 8; i++) send_bit(v[i], int'($urandom_range(maxgap, 0)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
  endtask

  task automatic check_status(input string tag, input int rdy, input int bsy, input int plen,
                              input int o6, input int o4);
    chk({tag, "_ready6"}, int'(rdy6), rdy);
    chk({tag, "_ready4"}, int'(rdy4), rdy);
    chk({tag, "_busy6"}, int'(busy6), bsy);
    chk({tag, "_busy4"}, int'(busy4), bsy);
    chk({tag, "_len6"}, int'(len6), plen);
    chk({tag, "_len4"}, int'(len4), plen);
    chk({tag, "_ovf6"}, int'(ov6), o6);
    chk({tag, "_ovf4"}, int'(ov4), o4);
    chk({tag, "_drop6"}, int'(drop6), exp_drop);
    chk({tag, "_drop4"}, int'(drop4), exp_drop);
  endtask

  // Called at the negedge right after the final bit's sampling edge.
  task automatic finish_packet(input string tag, input int exp_len, input int o6, input int o4,
                               input bit do_ack);
    chk({tag, "_lastwr6"}, int'(we6), (exp_len <= 64) ? 1 : 0);
    chk({tag, "_ready_early"}, int'(rdy6), 0);
    chk({tag, "_busy_last"}, int'(busy6), 1);
    tick();
    check_status(tag, 1, 0, exp_len, o6, o4);
    chk({tag, "_wr_after"}, int'(we6), 0);
    chk({tag, "_pending6"}, q6.size(), 0);
    chk({tag, "_pending4"}, q4.size(), 0);
    $display("pkt %s: len6=%0d ovf6=%0d ovf4=%0d ready=%0d", tag, len6, ov6, ov4, rdy6);
    if (do_ack) begin
      pkt_ack = 1'b1;
      tick();
      pkt_ack = 1'b0;
      chk({tag, "_ack_ready6"}, int'(rdy6), 0);
      chk({tag, "_ack_ready4"}, int'(rdy4), 0);
    end
  endtask

  task automatic run_packet(input string tag, input logic [7:0] hdr0, input logic [7:0] len,
                            input int gap, input int exp_len, input int o6, input int o4,
                            input bit do_start, input bit do_ack);
    if (do_start) pulse_start();
    send_byte(hdr0, gap);
    send_byte(len, gap);
    for (int i = 0; i < int'(len) + 3; i++) send_byte(8'($urandom), gap);
    finish_packet(tag, exp_len, o6, o4, do_ack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pkt1[8];
    pkt1 = '{8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
    tbl[0] = '{8'h00, 8'd20, 1, 25, 0, 1};
    tbl[1] = '{8'h41, 8'd0,  2, 5,  0, 0};
    tbl[2] = '{8'h12, 8'd11, 0, 16, 0, 0};
    tbl[3] = '{8'h13, 8'd12, 1, 17, 0, 1};
    tbl[4] = '{8'h05, 8'd59, 0, 64, 0, 1};
    tbl[5] = '{8'h06, 8'd60, 1, 65, 1, 1};

    // Reset state
    tick(); tick();
    check_status("reset", 0, 0, 0, 0, 0);
    chk("reset_wr6", int'(we6), 0);
    chk("reset_wr4", int'(we4), 0);
    rst = 1'b0;
    tick();

    // Fixed 8-byte packet with gaps between bits
    pulse_start();
    chk("start_busy", int'(busy6), 1);
    foreach (pkt1[i]) send_byte(pkt1[i], 2);
    finish_packet("pkt1", 8, 0, 0, 1'b1);

    // Table of packets around both buffer-depth boundaries
    for (int v = 0; v < 6; v++)
      run_packet($sformatf("tbl%0d", v), tbl[v].hdr0, tbl[v].len, tbl[v].gap,
                 tbl[v].exp_len, tbl[v].exp_ov6, tbl[v].exp_ov4, 1'b1, 1'b1);

    // Abort partway through a payload byte; a bit in the abort cycle is dropped
    pulse_start();
    send_byte(8'h00, 1); send_byte(8'h05, 1); send_byte(8'h5A, 1); send_byte(8'hC3, 1);
    send_bit(1'b1, 0); send_bit(1'b0, 1); send_bit(1'b1, 0);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    chk("abort_busy", int'(busy6), 0);
    chk("abort_ready", int'(rdy6), 0);
    for (int i = 0; i < 16; i++) send_bit(i[0], 0);
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
    chk("abort_idle_busy", int'(busy6), 0);
    chk("abort_pending6", q6.size(), 0);
    run_packet("after_abort", 8'h00, 8'd0, 1, 5, 0, 0, 1'b1, 1'b1);

    // Starts refused while a packet is held, then ack+start together
    run_packet("hold", 8'h01, 8'd1, 0, 6, 0, 0, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    exp_drop = 2;
    check_status("drops", 1, 0, 6, 0, 0);
    pkt_ack = 1'b1; start = 1'b1;
    tick();
    pkt_ack = 1'b0; start = 1'b0;
    idx = 0;
    chk("ackstart_busy6", int'(busy6), 1);
    chk("ackstart_busy4", int'(busy4), 1);
    chk("ackstart_ready", int'(rdy6), 0);
    chk("ackstart_drop", int'(drop6), 2);
    run_packet("ackstart", 8'h00, 8'd2, 1, 7, 0, 0, 1'b0, 1'b1);

    // Resync: start after 12 header bits
    pulse_start();
    send_byte(8'hA5, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    run_packet("resync", 8'h3C, 8'd1, 1, 6, 0, 0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a payload
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'd10, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    chk("pre_rst_busy", int'(busy6), 1);
    #2 rst = 1'b1;
    #1;
    exp_drop = 0;
    check_status("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst_wr6", int'(we6), 0);
    q6.delete(); q4.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
    run_packet("post_rst", 8'h02, 8'd4, 1, 9, 0, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
